// File: rtl/main_mem_arbiter.sv
// Arbiter for the single main-memory port shared by instruction fetch and data load/store.
// One transaction in flight; priority write > read > fetch with a fetch starvation guard.
module main_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic [31:0] dread_addr,
  input  logic        dread_valid,
  output logic [31:0] dread_data,
  output logic        dread_ready,
  input  logic [31:0] dwrite_addr,
  input  logic [31:0] dwrite_data,
  input  logic        dwrite_valid,
  output logic        dwrite_ready,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_data,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  output logic [31:0] mem_out_addr,
  output logic        mem_out_valid,
  input  logic [31:0] mem_out_data,
  input  logic        mem_out_ready,
  output logic        busy
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2,
    WR_DATA  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [SW-1:0] streak_inc_s;
  logic [31:0]   mem_in_addr_q, mem_in_addr_d;
  logic [31:0]   mem_in_data_q, mem_in_data_d;
  logic          mem_in_valid_q, mem_in_valid_d;
  logic [31:0]   mem_out_addr_q, mem_out_addr_d;
  logic          mem_out_valid_q, mem_out_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      streak_q        <= '0;
      mem_in_addr_q   <= 32'h0;
      mem_in_data_q   <= 32'h0;
      mem_in_valid_q  <= 1'b0;
      mem_out_addr_q  <= 32'h0;
      mem_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      streak_q        <= streak_d;
      mem_in_addr_q   <= mem_in_addr_d;
      mem_in_data_q   <= mem_in_data_d;
      mem_in_valid_q  <= mem_in_valid_d;
      mem_out_addr_q  <= mem_out_addr_d;
      mem_out_valid_q <= mem_out_valid_d;
    end
  end

  // A data grant only counts towards starvation while fetch is actually waiting.
  assign streak_inc_s = (streak_q == STREAK_MAX) ? streak_q : streak_q + {{(SW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    mem_in_addr_d   = mem_in_addr_q;
    mem_in_data_d   = mem_in_data_q;
    mem_in_valid_d  = mem_in_valid_q;
    mem_out_addr_d  = mem_out_addr_q;
    mem_out_valid_d = mem_out_valid_q;
    case (state_q)
      IDLE: begin
        if (fetch_valid && (streak_q == STREAK_MAX)) begin
          state_d         = RD_FETCH;
          mem_out_addr_d  = fetch_addr;
          mem_out_valid_d = 1'b1;
          streak_d        = '0;
        end else if (dwrite_valid) begin
          state_d        = WR_DATA;
          mem_in_addr_d  = dwrite_addr;
          mem_in_data_d  = dwrite_data;
          mem_in_valid_d = 1'b1;
          streak_d       = fetch_valid ? streak_inc_s : '0;
        end else if (dread_valid) begin
          state_d         = RD_DATA;
          mem_out_addr_d  = dread_addr;
          mem_out_valid_d = 1'b1;
          streak_d        = fetch_valid ? streak_inc_s : '0;
        end else if (fetch_valid) begin
          state_d         = RD_FETCH;
          mem_out_addr_d  = fetch_addr;
          mem_out_valid_d = 1'b1;
          streak_d        = '0;
        end else begin
          streak_d = '0;
        end
      end
      RD_FETCH, RD_DATA: begin
        if (mem_out_valid_q && mem_out_ready) begin
          state_d         = IDLE;
          mem_out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      WR_DATA: begin
        if (mem_in_valid_q && mem_in_ready) begin
          state_d        = IDLE;
          mem_in_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d         = IDLE;
        mem_in_valid_d  = 1'b0;
        mem_out_valid_d = 1'b0;
      end
    endcase
  end

  // Completion pulses are combinational so the requester sees ready in the memory's ready cycle.
  assign fetch_ready  = (state_q == RD_FETCH) && mem_out_valid_q && mem_out_ready;
  assign dread_ready  = (state_q == RD_DATA)  && mem_out_valid_q && mem_out_ready;
  assign dwrite_ready = (state_q == WR_DATA)  && mem_in_valid_q  && mem_in_ready;
  assign fetch_data   = mem_out_data;
  assign dread_data   = mem_out_data;

  assign mem_in_addr   = mem_in_addr_q;
  assign mem_in_data   = mem_in_data_q;
  assign mem_in_valid  = mem_in_valid_q;
  assign mem_out_addr  = mem_out_addr_q;
  assign mem_out_valid = mem_out_valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: expected completions are queued as requests are raised
// and compared against completions observed at the requester ports.
module tb_main_mem_arbiter;

  typedef struct {
    int          kind;   // 0 read grant, 1 fetch, 2 data read, 3 data write
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = 32'h0, dread_addr = 32'h0, dwrite_addr = 32'h0, dwrite_data = 32'h0;
  logic        fetch_valid = 1'b0, dread_valid = 1'b0, dwrite_valid = 1'b0;
  logic [31:0] fetch_data, dread_data, mem_in_addr, mem_in_data, mem_out_addr, mem_out_data;
  logic        fetch_ready, dread_ready, dwrite_ready, mem_in_valid, mem_out_valid, busy;
  logic        mem_in_ready, mem_out_ready;
  logic        auto_in_ready = 1'b0, auto_out_ready = 1'b0;
  logic        man_in_ready = 1'b0, man_out_ready = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  int          rd_lat = 0, wr_lat = 0, rd_cnt = 0, wr_cnt = 0;
  logic        hold_fetch = 1'b0, hold_dread = 1'b0;
  logic        prev_in_v = 1'b0, prev_out_v = 1'b0;
  int          cyc = 0;
  int          illegal_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  ev_t         grant_q[$];

  main_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .dread_addr(dread_addr), .dread_valid(dread_valid), .dread_data(dread_data), .dread_ready(dread_ready),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_valid(dwrite_valid),
    .dwrite_ready(dwrite_ready),
    .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
    .mem_in_ready(mem_in_ready),
    .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid), .mem_out_data(mem_out_data),
    .mem_out_ready(mem_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_in_ready  = auto_in_ready | man_in_ready;
  assign mem_out_ready = auto_out_ready | man_out_ready;
  assign mem_out_data  = model_rdata(mem_out_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers a request after a programmable number of wait cycles.
  always @(negedge clk) begin
    if (mem_out_valid === 1'b1) begin
      rd_cnt         <= rd_cnt + 1;
      auto_out_ready <= rd_en && (rd_cnt + 1 > rd_lat);
    end else begin
      rd_cnt         <= 0;
      auto_out_ready <= 1'b0;
    end
    if (mem_in_valid === 1'b1) begin
      wr_cnt        <= wr_cnt + 1;
      auto_in_ready <= wr_en && (wr_cnt + 1 > wr_lat);
    end else begin
      wr_cnt        <= 0;
      auto_in_ready <= 1'b0;
    end
  end

  // Monitor: records grants and completions with their cycle number.
  always @(negedge clk) begin
    #1;
    if (mem_out_valid === 1'b1 && !prev_out_v) grant_q.push_back('{0, mem_out_addr, 32'h0, cyc});
    if (mem_in_valid === 1'b1 && !prev_in_v)   grant_q.push_back('{3, mem_in_addr, mem_in_data, cyc});
    if (fetch_ready === 1'b1)  obs_q.push_back('{1, mem_out_addr, fetch_data, cyc});
    if (dread_ready === 1'b1)  obs_q.push_back('{2, mem_out_addr, dread_data, cyc});
    if (dwrite_ready === 1'b1) obs_q.push_back('{3, mem_in_addr, mem_in_data, cyc});
    if ((int'(fetch_ready === 1'b1) + int'(dread_ready === 1'b1) + int'(dwrite_ready === 1'b1)) > 1 ||
        (mem_in_valid === 1'b1 && mem_out_valid === 1'b1))
      illegal_cnt <= illegal_cnt + 1;
    prev_out_v <= (mem_out_valid === 1'b1);
    prev_in_v  <= (mem_in_valid === 1'b1);
  end

  // Requesters drop valid in their ready cycle unless told to keep requesting.
  task automatic tick();
    @(negedge clk);
    #2;
    if (fetch_ready === 1'b1 && !hold_fetch) fetch_valid = 1'b0;
    if (dread_ready === 1'b1 && !hold_dread) dread_valid = 1'b0;
    if (dwrite_ready === 1'b1) dwrite_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (mem_in_valid !== 1'b0 || mem_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: got in=%b out=%b expected 0 0", mem_in_valid, mem_out_valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if ({fetch_ready, dread_ready, dwrite_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_readies: got %b expected 000", {fetch_ready, dread_ready, dwrite_ready});
    end
    n_checks++;
    if (mem_in_addr !== 32'h0 || mem_in_data !== 32'h0 || mem_out_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h %h %h expected zeros", mem_in_addr, mem_in_data, mem_out_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    int ob = obs_q.size();
    int gb = grant_q.size();
    int t0;
    ev_t e, o;
    rd_en = 1'b1; rd_lat = 3;
    exp_q.push_back('{1, 32'h100, 32'hDEADBEEF, 0});
    fetch_addr = 32'h100; fetch_valid = 1'b1; t0 = cyc;
    for (int c = 0; c < 50; c++) begin
      if (obs_q.size() >= ob + 1) break;
      tick();
    end
    n_checks++;
    if (obs_q.size() < ob + 1) begin
      n_fail++; $display("FAIL fetch_only_timeout: got %0d completions expected 1", obs_q.size() - ob);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q[ob];
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
        n_fail++; $display("FAIL fetch_only_txn: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                           o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      end
      n_checks++;
      if (grant_q.size() <= gb || grant_q[gb].cyc !== t0 + 1 || o.cyc !== t0 + 4) begin
        n_fail++; $display("FAIL fetch_only_latency: got completion cycle %0d expected %0d", o.cyc, t0 + 4);
      end
    end
    tick();
    n_checks++;
    if (mem_out_valid !== 1'b0 || busy !== 1'b0 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_only_drop: got valid=%b busy=%b expected 0 0", mem_out_valid, busy);
    end
  endtask

  task automatic test_collision();
    int ob = obs_q.size();
    int gb = grant_q.size();
    int t0;
    ev_t e, o;
    rd_en = 1'b1; rd_lat = 1; wr_en = 1'b1; wr_lat = 1;
    exp_q.push_back('{3, 32'h300, 32'h55, 0});
    exp_q.push_back('{2, 32'h200, 32'h5A5A_0200, 0});
    exp_q.push_back('{1, 32'h100, 32'hDEADBEEF, 0});
    fetch_addr = 32'h100; dread_addr = 32'h200; dwrite_addr = 32'h300; dwrite_data = 32'h55;
    fetch_valid = 1'b1; dread_valid = 1'b1; dwrite_valid = 1'b1; t0 = cyc;
    for (int c = 0; c < 100; c++) begin
      if (obs_q.size() >= ob + 3) break;
      tick();
    end
    n_checks++;
    if (obs_q.size() < ob + 3) begin
      n_fail++; $display("FAIL collision_timeout: got %0d completions expected 3", obs_q.size() - ob);
      exp_q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front(); o = obs_q[ob + i];
        n_checks++;
        if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
          n_fail++; $display("FAIL collision_txn%0d: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                             i, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
        end
      end
      n_checks++;
      if (grant_q.size() < gb + 3 || grant_q[gb].cyc !== t0 + 1) begin
        n_fail++; $display("FAIL collision_first_grant: got %0d grants expected first at cycle %0d",
                           grant_q.size() - gb, t0 + 1);
      end else begin
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (grant_q[gb + i + 1].cyc !== obs_q[ob + i].cyc + 2) begin
            n_fail++; $display("FAIL collision_bubble%0d: got grant cycle %0d expected %0d",
                               i, grant_q[gb + i + 1].cyc, obs_q[ob + i].cyc + 2);
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_starvation();
    int gb = grant_q.size();
    logic [31:0] want;
    rd_en = 1'b1; rd_lat = 0;
    hold_fetch = 1'b1; hold_dread = 1'b1;
    fetch_addr = 32'h1A0; dread_addr = 32'h2A0;
    fetch_valid = 1'b1; dread_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (grant_q.size() >= gb + 10) break;
      tick();
    end
    hold_fetch = 1'b0; hold_dread = 1'b0;
    n_checks++;
    if (grant_q.size() < gb + 10) begin
      n_fail++; $display("FAIL starvation_timeout: got %0d grants expected 10", grant_q.size() - gb);
    end else begin
      for (int i = 0; i < 10; i++) begin
        want = ((i % 5) == 4) ? 32'h1A0 : 32'h2A0;
        n_checks++;
        if (grant_q[gb + i].addr !== want) begin
          n_fail++; $display("FAIL starvation_grant%0d: got addr %h expected %h", i, grant_q[gb + i].addr, want);
        end
      end
    end
    for (int c = 0; c < 100; c++) begin
      if (!fetch_valid && !dread_valid && busy === 1'b0) break;
      tick();
    end
    n_checks++;
    if (fetch_valid || dread_valid || busy !== 1'b0) begin
      n_fail++; $display("FAIL starvation_drain: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_zero_wait();
    int ob = obs_q.size();
    int gb = grant_q.size();
    int t0;
    ev_t e, o;
    rd_en = 1'b0; wr_en = 1'b0;
    man_in_ready = 1'b1; man_out_ready = 1'b1;
    exp_q.push_back('{3, 32'h340, 32'h77, 0});
    exp_q.push_back('{2, 32'h240, 32'h5A5A_0240, 0});
    exp_q.push_back('{1, 32'h140, 32'h5A5A_0140, 0});
    fetch_addr = 32'h140; dread_addr = 32'h240; dwrite_addr = 32'h340; dwrite_data = 32'h77;
    fetch_valid = 1'b1; dread_valid = 1'b1; dwrite_valid = 1'b1; t0 = cyc;
    for (int c = 0; c < 50; c++) begin
      if (obs_q.size() >= ob + 3) break;
      tick();
    end
    tick(); tick(); tick();
    n_checks++;
    if (obs_q.size() !== ob + 3 || grant_q.size() !== gb + 3) begin
      n_fail++; $display("FAIL zero_wait_count: got %0d completions %0d grants expected 3 3",
                         obs_q.size() - ob, grant_q.size() - gb);
      exp_q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front(); o = obs_q[ob + i];
        n_checks++;
        if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data ||
            grant_q[gb + i].cyc !== t0 + 1 + 2 * i || o.cyc !== t0 + 1 + 2 * i) begin
          n_fail++; $display("FAIL zero_wait_txn%0d: got kind %0d addr %h data %h cycle %0d expected kind %0d addr %h data %h cycle %0d",
                             i, o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, t0 + 1 + 2 * i);
        end
      end
    end
    man_in_ready = 1'b0; man_out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int ob = obs_q.size();
    rd_en = 1'b0;
    dread_addr = 32'h280; dread_valid = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (mem_out_valid !== 1'b1 || mem_out_addr !== 32'h280) begin
      n_fail++; $display("FAIL midreset_pending: got valid=%b addr=%h expected 1 00000280", mem_out_valid, mem_out_addr);
    end
    reset = 1'b1; dread_valid = 1'b0;
    tick();
    n_checks++;
    if (mem_out_valid !== 1'b0 || busy !== 1'b0 || dread_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_abort: got valid=%b busy=%b ready=%b expected 0 0 0",
                         mem_out_valid, busy, dread_ready);
    end
    reset = 1'b0;
    tick();
    man_out_ready = 1'b1;
    tick();
    n_checks++;
    if ({fetch_ready, dread_ready, dwrite_ready} !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_late_ready: got readies %b busy %b expected 000 0",
                         {fetch_ready, dread_ready, dwrite_ready}, busy);
    end
    man_out_ready = 1'b0;
    tick();
    n_checks++;
    if (obs_q.size() !== ob) begin
      n_fail++; $display("FAIL midreset_no_pulse: got %0d completions expected 0", obs_q.size() - ob);
    end
  endtask

  task automatic test_spurious_ready();
    int ob = obs_q.size();
    ev_t e, o;
    man_in_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (dwrite_ready !== 1'b0 || busy !== 1'b0 || mem_in_valid !== 1'b0) begin
      n_fail++; $display("FAIL spurious_idle: got ready=%b busy=%b expected 0 0", dwrite_ready, busy);
    end
    rd_en = 1'b1; rd_lat = 3;
    exp_q.push_back('{1, 32'h1C0, 32'h5A5A_01C0, 0});
    fetch_addr = 32'h1C0; fetch_valid = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1 || dwrite_ready !== 1'b0 || mem_out_valid !== 1'b1 || mem_in_valid !== 1'b0) begin
      n_fail++; $display("FAIL spurious_fetch: got busy=%b wready=%b rvalid=%b wvalid=%b expected 1 0 1 0",
                         busy, dwrite_ready, mem_out_valid, mem_in_valid);
    end
    for (int c = 0; c < 50; c++) begin
      if (obs_q.size() >= ob + 1) break;
      tick();
    end
    n_checks++;
    if (obs_q.size() !== ob + 1) begin
      n_fail++; $display("FAIL spurious_complete: got %0d completions expected 1", obs_q.size() - ob);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q[ob];
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
        n_fail++; $display("FAIL spurious_txn: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                           o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      end
    end
    man_in_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_collision();
    test_starvation();
    test_zero_wait();
    test_reset_mid_read();
    test_spurious_ready();
    n_checks++;
    if (illegal_cnt !== 0) begin
      n_fail++; $display("FAIL exclusivity: got %0d bad cycles expected 0", illegal_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
